// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   Contents: state encodings, default watchdog limit, per-stage control bundle
//   and the canned control sets the sequencer chooses between.
package pipeline_stall_controller_pkg;

  localparam logic [1:0] STATE_IDLE     = 2'b00;
  localparam logic [1:0] STATE_RUN      = 2'b01;
  localparam logic [1:0] STATE_MEM_WAIT = 2'b10;
  localparam logic [1:0] STATE_HALT     = 2'b11;

  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE     = STATE_IDLE,
    RUN      = STATE_RUN,
    MEM_WAIT = STATE_MEM_WAIT,
    HALT     = STATE_HALT
  } state_t;

  // Per-stage pipeline register controls, excluding the memory request.
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_bubble;
    logic idex_write;
    logic exmem_write;
    logic memwb_bubble;
  } ctrl_t;

  // Pipeline held completely still; used in IDLE and HALT.
  localparam ctrl_t CTRL_FROZEN = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                    idex_bubble: 1'b1, idex_write: 1'b0, exmem_write: 1'b0,
                                    memwb_bubble: 1'b1};
  // Everything up to MEM holds; WB drains behind a bubble.
  localparam ctrl_t CTRL_MEM_STALL = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                       idex_bubble: 1'b0, idex_write: 1'b0, exmem_write: 1'b0,
                                       memwb_bubble: 1'b1};
  // Front end holds, a bubble is injected into EX, the back end moves on.
  localparam ctrl_t CTRL_LOAD_USE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                                      idex_bubble: 1'b1, idex_write: 1'b1, exmem_write: 1'b1,
                                      memwb_bubble: 1'b0};
  // Taken branch: the wrong-path fetch in IF/ID becomes a NOP.
  localparam ctrl_t CTRL_FLUSH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1,
                                   idex_bubble: 1'b0, idex_write: 1'b1, exmem_write: 1'b1,
                                   memwb_bubble: 1'b0};
  localparam ctrl_t CTRL_NORMAL = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
                                    idex_bubble: 1'b0, idex_write: 1'b1, exmem_write: 1'b1,
                                    memwb_bubble: 1'b0};

endpackage

// File: rtl/pipeline_stall_controller_if.sv
// Bundle of all hazard inputs, pipeline controls and status of the stall controller.
// Latency: n/a (wiring only).
// Backpressure: n/a; mem_req_o/mem_ack_i form the data-memory request/ack pair.
//   master: the controller (drives controls, memory request, status).
//   slave : the pipeline/environment (drives hazard flags, start and memory ack).
interface pipeline_stall_controller_if #(
  parameter int CNT_W = 32
) ();

  logic             start_i;
  logic             ld_use_i;
  logic             branch_taken_i;
  logic             mem_access_i;
  logic             mem_ack_i;
  logic             mem_req_o;
  logic             pc_write_o;
  logic             ifid_write_o;
  logic             ifid_flush_o;
  logic             idex_bubble_o;
  logic             idex_write_o;
  logic             exmem_write_o;
  logic             memwb_bubble_o;
  logic [1:0]       state_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;
  logic             timeout_o;

  modport master (
    input  start_i, ld_use_i, branch_taken_i, mem_access_i, mem_ack_i,
    output mem_req_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           idex_write_o, exmem_write_o, memwb_bubble_o, state_o,
           stall_cnt_o, flush_cnt_o, timeout_o
  );

  modport slave (
    output start_i, ld_use_i, branch_taken_i, mem_access_i, mem_ack_i,
    input  mem_req_o, pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o,
           idex_write_o, exmem_write_o, memwb_bubble_o, state_o,
           stall_cnt_o, flush_cnt_o, timeout_o
  );

endinterface

// File: rtl/pipeline_stall_controller_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
// Latency: count reflects an inc one clock after it is sampled.
// Backpressure: none; sticks at all-ones once reached.
//   Ports: clk, rst_n (async active-low), inc (count this cycle), count (value).
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Central stall/flush sequencer for the 5-stage pipeline, with memory watchdog and perf counters.
// Latency: stage controls and mem_req are combinational from state + inputs; status is registered.
// Backpressure: a memory access without same-cycle ack freezes the pipe until ack or timeout.
//   Ports: clk_i, rst_i (async active-low), bus (master side of pipeline_stall_controller_if).
module pipeline_stall_controller
  import pipeline_stall_controller_pkg::*;
#(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  pipeline_stall_controller_if.master   bus
);

  localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_q;
  ctrl_t             ctrl;

  logic pipe_active;
  logic mem_active;
  logic mem_stall;
  logic ld_stall;
  logic wd_expire;

  // Hazard qualification shared by next-state, output and counter logic.
  // Hazard flags only matter while the pipe is running and not held by memory.
  assign pipe_active = (state == RUN) || (state == MEM_WAIT);
  assign mem_active  = ((state == RUN) && bus.mem_access_i) || (state == MEM_WAIT);
  assign mem_stall   = mem_active && !bus.mem_ack_i;
  assign ld_stall    = pipe_active && !mem_stall && bus.ld_use_i;
  assign wd_expire   = (state == MEM_WAIT) && !bus.mem_ack_i && (wait_cnt == WAIT_LIMIT);

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start_i) state_nxt = RUN;
      end
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
        end else if (!bus.start_i && !ld_stall) begin
          state_nxt = IDLE;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_ack_i) begin
          state_nxt = bus.start_i ? RUN : IDLE;
        end else if (wd_expire) begin
          state_nxt = HALT;
        end
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: pick one canned control set by priority.
  always_comb begin
    ctrl          = CTRL_FROZEN;
    bus.mem_req_o = mem_active;
    if (pipe_active) begin
      if (mem_stall) begin
        ctrl = CTRL_MEM_STALL;
      end else if (bus.ld_use_i) begin
        // A simultaneous taken branch is dropped; it re-resolves once the bubble clears.
        ctrl = CTRL_LOAD_USE;
      end else if (bus.branch_taken_i) begin
        ctrl = CTRL_FLUSH;
      end else begin
        ctrl = CTRL_NORMAL;
      end
    end
  end

  assign bus.pc_write_o     = ctrl.pc_write;
  assign bus.ifid_write_o   = ctrl.ifid_write;
  assign bus.ifid_flush_o   = ctrl.ifid_flush;
  assign bus.idex_bubble_o  = ctrl.idex_bubble;
  assign bus.idex_write_o   = ctrl.idex_write;
  assign bus.exmem_write_o  = ctrl.exmem_write;
  assign bus.memwb_bubble_o = ctrl.memwb_bubble;
  assign bus.state_o        = state;
  assign bus.timeout_o      = timeout_q;

  // Watchdog: counts unacknowledged MEM_WAIT cycles; zero whenever outside MEM_WAIT
  // so every entry starts fresh. It never wraps because the limit forces HALT.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state != MEM_WAIT) begin
        wait_cnt <= '0;
      end else if (!bus.mem_ack_i) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
      if (wd_expire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  // Perf counters; both inc terms are zero in IDLE/HALT so they hold there.
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .inc   (mem_stall || ld_stall),
    .count (bus.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst_n (rst_i),
    .inc   (ctrl.ifid_flush),
    .count (bus.flush_cnt_o)
  );

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench: driver applies inputs after each rising edge and pushes the reference
// model's expected outputs; a monitor pops and compares on every falling edge.
module tb_pipeline_stall_controller;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Expected output word order: mem_req, pc_write, ifid_write, ifid_flush,
  // idex_bubble, idex_write, exmem_write, memwb_bubble.
  localparam logic [7:0] P_FROZEN   = 8'b0000_1001;
  localparam logic [7:0] P_MEMSTALL = 8'b1000_0001;
  localparam logic [7:0] P_LOADUSE  = 8'b0000_1110;
  localparam logic [7:0] P_FLUSH    = 8'b0111_0110;
  localparam logic [7:0] P_NORMAL   = 8'b0110_0110;

  typedef struct {
    logic [7:0] ctl;
    logic [1:0] st;
    int         stall;
    int         flush;
    logic       to;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipeline_stall_controller_if #(.CNT_W(CNT_W)) bus ();

  pipeline_stall_controller #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: plain description of the controller's behaviour.
  // mode: 0 idle, 1 running, 2 waiting on memory, 3 halted by watchdog.
  int   m_mode = 0;
  int   m_waited = 0;
  int   m_stall = 0;
  int   m_flush = 0;
  logic m_to = 1'b0;

  function automatic void model_step(logic r, logic s, logic ld, logic br, logic acc, logic ack);
    exp_t e;
    bit   held_by_mem;
    if (!r) begin
      m_mode = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_to = 1'b0;
      e.ctl = P_FROZEN; e.st = 2'd0; e.stall = 0; e.flush = 0; e.to = 1'b0;
      exp_q.push_back(e);
      return;
    end
    e.st = 2'(m_mode); e.stall = m_stall; e.flush = m_flush; e.to = m_to;
    if (m_mode == 0 || m_mode == 3) begin
      e.ctl = P_FROZEN;
      if (m_mode == 0 && s) m_mode = 1;
    end else begin
      held_by_mem = (m_mode == 2) ? !ack : (acc && !ack);
      if (held_by_mem)  e.ctl = P_MEMSTALL;
      else if (ld)      e.ctl = P_LOADUSE;
      else if (br)      e.ctl = P_FLUSH;
      else              e.ctl = P_NORMAL;
      if (m_mode == 2 || acc) e.ctl[7] = 1'b1;
      if ((held_by_mem || ld) && m_stall < CNT_MAX) m_stall++;
      if (!held_by_mem && !ld && br && m_flush < CNT_MAX) m_flush++;
      if (m_mode == 1) begin
        if (held_by_mem) begin
          m_mode = 2; m_waited = 0;
        end else if (!s && !ld) begin
          m_mode = 0;
        end
      end else if (ack) begin
        m_mode = s ? 1 : 0;
      end else if (m_waited + 1 == TIMEOUT) begin
        m_mode = 3; m_to = 1'b1;
      end else begin
        m_waited++;
      end
    end
    exp_q.push_back(e);
  endfunction

  task automatic drive(input logic r, input logic s, input logic ld, input logic br,
                       input logic acc, input logic ack);
    @(posedge clk);
    #1;
    rst_n = r;
    bus.start_i = s; bus.ld_use_i = ld; bus.branch_taken_i = br;
    bus.mem_access_i = acc; bus.mem_ack_i = ack;
    model_step(r, s, ld, br, acc, ack);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // Monitor: one expected record per cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [7:0] got;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = {bus.mem_req_o, bus.pc_write_o, bus.ifid_write_o, bus.ifid_flush_o,
             bus.idex_bubble_o, bus.idex_write_o, bus.exmem_write_o, bus.memwb_bubble_o};
      check("controls", int'(got), int'(e.ctl));
      check("state", int'(bus.state_o), int'(e.st));
      check("stall_cnt", int'(bus.stall_cnt_o), e.stall);
      check("flush_cnt", int'(bus.flush_cnt_o), e.flush);
      check("timeout", int'(bus.timeout_o), int'(e.to));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL sim_time_limit: bench did not finish, expected completion");
    $fatal(1, "time limit");
  end

  initial begin
    bus.start_i = 1'b0; bus.ld_use_i = 1'b0; bus.branch_taken_i = 1'b0;
    bus.mem_access_i = 1'b0; bus.mem_ack_i = 1'b0;

    // Reset and start.
    drive(0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 1);
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    // Memory access with ack three cycles late.
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 1, 0, 0, 1, 1);
    drive(1, 1, 0, 0, 0, 0);
    // Same-cycle hit.
    drive(1, 1, 0, 0, 1, 1);
    // Load-use together with branch, then branch alone.
    drive(1, 1, 1, 1, 0, 0);
    drive(1, 1, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    // Hazard flags during MEM_WAIT, then load-use in the ack cycle.
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 1, 1, 1, 1, 0);
    drive(1, 1, 1, 1, 0, 1);
    drive(1, 1, 0, 0, 0, 0);
    // Stop requests: held by load-use, then released.
    drive(1, 0, 1, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 0);
    drive(1, 1, 0, 0, 0, 0);
    // Watchdog expiry, ignored stimulus in HALT, reset recovery.
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 0);
    for (int i = 0; i < TIMEOUT; i++) drive(1, 1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 1, 1);
    drive(1, 1, 1, 1, 1, 1);
    drive(1, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    // Ack in MEM_WAIT with start low returns to IDLE.
    drive(1, 1, 0, 0, 0, 0);
    drive(1, 1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0);

    // Randomized traffic; counters are narrow so saturation is exercised.
    for (int i = 0; i < 4000; i++) begin
      logic r;
      r = !(($urandom_range(0, 299) == 0) || (m_mode == 3 && $urandom_range(0, 15) == 0));
      drive(r, $urandom_range(0, 9) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 4) < 2);
    end
    drive(1, 0, 0, 0, 0, 0);

    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Central sequencer for the 5-stage RISC-V pipeline.
- Merges three stall/flush sources into one consistent set of per-stage write/bubble/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB:
  - load-use hazard flag from the hazard detection unit;
  - branch-taken redirect from ID;
  - multi-cycle data-memory handshake.
- Also owns the data-memory request handshake, a miss watchdog, and stall/flush performance counters.

Parameters:
CNT_W, 32, width of stall_cnt_o / flush_cnt_o.
TIMEOUT, 1024, max cycles in MEM_WAIT before declaring a memory timeout (>=2).

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous active-low reset.
start_i  input  1  pipeline run enable.
ld_use_i  input  1  load-use hazard (stall request from hazard detection unit).
branch_taken_i  input  1  branch resolved taken in ID this cycle.
mem_access_i  input  1  MEM stage holds a load or store (MemRead | MemWrite).
mem_ack_i  input  1  data memory completion, one-cycle pulse.
mem_req_o  output  1  data memory request.
pc_write_o  output  1  1 = PC updates.
ifid_write_o  output  1  1 = IF/ID register loads.
ifid_flush_o  output  1  1 = IF/ID loads a NOP.
idex_bubble_o  output  1  1 = ID/EX loads zeroed control (bubble).
idex_write_o  output  1  1 = ID/EX register loads.
exmem_write_o  output  1  1 = EX/MEM register loads.
memwb_bubble_o  output  1  1 = MEM/WB loads zeroed control.
state_o  output  2  FSM state, debug.
stall_cnt_o  output  CNT_W  saturating count of stall cycles.
flush_cnt_o  output  CNT_W  saturating count of flush cycles.
timeout_o  output  1  sticky memory-timeout flag.

Behaviour:
- States and encoding: IDLE=2'b00, RUN=2'b01, MEM_WAIT=2'b10, HALT=2'b11.
- Reset (rst_i low, async):
  - state IDLE, counters 0, timeout_o 0, wait counter 0.
  - Outputs take IDLE values.
- Control outputs are combinational from state and inputs; all other storage is registered.
- IDLE "frozen" output set:
  - pc_write, ifid_write, idex_write, exmem_write = 0;
  - idex_bubble = 1, memwb_bubble = 1;
  - mem_req = 0, ifid_flush = 0.
- Transitions:
  - IDLE -> RUN when start_i=1.
  - RUN -> IDLE when start_i=0 and no stall condition exists.
- RUN, mem_access_i=1:
  - mem_req_o=1.
  - If mem_ack_i=1 the same cycle (hit): no stall.
  - Otherwise mem-stall this cycle and next state MEM_WAIT.
- Mem-stall output set:
  - pc_write, ifid_write, idex_write, exmem_write = 0;
  - memwb_bubble = 1;
  - idex_bubble = 0, ifid_flush = 0.
- MEM_WAIT:
  - mem_req_o=1; mem-stall held while mem_ack_i=0.
  - On mem_ack_i=1: stall released that same cycle and pipeline advances.
  - Next state RUN if start_i=1, else IDLE.
- Priority when not mem-stalled:
  - load-use beats branch; branch beats normal.
  - Load-use: pc_write=0, ifid_write=0, idex_bubble=1; all other writes 1.
  - Branch only: ifid_flush=1; all writes 1.
  - ld_use_i and branch_taken_i together: load-use only, no flush. The branch re-resolves next cycle.
  - During a mem-stall, ld_use_i and branch_taken_i are ignored.
- Normal: all writes 1, bubbles/flush 0.
- Watchdog:
  - Wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle without ack.
  - When it reaches TIMEOUT-1 with no ack: next state HALT, timeout_o set.
- HALT:
  - Outputs as IDLE; timeout_o=1.
  - Only reset exits HALT.
- Counters:
  - stall_cnt increments on every mem-stall or load-use cycle.
  - flush_cnt increments on every ifid_flush_o=1 cycle.
  - Both saturate at all-ones and hold in IDLE/HALT.
- mem_ack_i in IDLE or HALT, or in RUN with mem_access_i=0: ignored.

Decomposition:
- Shared constants go in Const.v:
  - state encodings STATE_IDLE, STATE_RUN, STATE_MEM_WAIT, STATE_HALT;
  - default TIMEOUT.
- One sub-module, sat_counter (parameterised width, inc enable, async active-low reset), instantiated twice for stall/flush counts.
- FSM and watchdog stay in the top module.

Test Plan:
- Reset, then start_i=1 one cycle:
  - IDLE outputs during reset: pc_write_o=0, memwb_bubble_o=1.
  - state_o=01 next cycle; all writes 1.
- RUN, mem_access_i=1 with ack delayed 3 cycles:
  - mem_req_o=1 for 4 cycles; pc_write_o=0 for 3 cycles, 1 in the ack cycle;
  - stall_cnt_o=3; state MEM_WAIT -> RUN.
- Same-cycle hit (mem_access_i=1, mem_ack_i=1) -> no stall, state stays RUN, stall_cnt_o unchanged.
- ld_use_i=1 and branch_taken_i=1 together:
  - idex_bubble_o=1, ifid_flush_o=0;
  - next cycle branch_taken_i alone -> ifid_flush_o=1, flush_cnt_o=1.
- ld_use_i=1 during MEM_WAIT -> outputs remain the mem-stall set, idex_bubble_o=0.
- TIMEOUT=4, no ack:
  - HALT after 4 MEM_WAIT cycles; timeout_o=1; mem_req_o=0.
  - Later mem_ack_i and start_i toggles are ignored; rst_i low returns to IDLE with timeout_o=0.
